slowclk_monitor: RTL

- Receiving end of the divided-clock path. Takes the slow clock produced by the divider and samples it as a data signal in the fast `inclk` domain.
- Converts it into single-cycle rise/fall enable ticks, so downstream logic can run on `inclk` with clock enables instead of a generated clock.
- Measures the half-period in `inclk` cycles and flags a stalled slow clock.
- Sits between the divider and the processor datapath/step logic.

---
 rtl/slowclk_monitor.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/slowclk_monitor.sv
// slowclk_monitor
//   Receiving end of the divided-clock path. The slow clock from the divider
//   is sampled as asynchronous data in the inclk domain. It is turned into
//   one-cycle rise/fall enable ticks. The half-period is measured in inclk
//   cycles, and a slow clock that stops toggling is flagged as stalled.
//
// Optional feature macro: SLOWCLK_PERIOD_CHECK_EN
//   When defined, every half-period reload in LOCKED is compared against the
//   expected value for the current divider mode. Any mismatch sets the sticky
//   period_err output. When undefined, the port and the compare logic are absent.
//
// Ports
//   inclk         in   fast system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   slowclk_in    in   divided clock, asynchronous data
//   switch_clock  in   [1:0] divider mode, 2'b01 = slow/counted, else toggle
//   rise_tick     out  one-cycle pulse per synchronized rising edge
//   fall_tick     out  one-cycle pulse per synchronized falling edge
//   half_period   out  [24:0] inclk cycles between the last two edges
//   period_valid  out  half_period measured in the current mode
//   stall         out  no edge seen for TIMEOUT cycles
//   period_err    out  sticky half-period mismatch (macro builds only)
module slowclk_monitor #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [24:0] TIMEOUT     = 25'd1000,
    parameter logic [24:0] EXP_MAX     = 25'd50
) (
    input  logic        inclk,
    input  logic        reset_n,
    input  logic        slowclk_in,
    input  logic [1:0]  switch_clock,
    output logic        rise_tick,
    output logic        fall_tick,
    output logic [24:0] half_period,
    output logic        period_valid,
    output logic        stall
`ifdef SLOWCLK_PERIOD_CHECK_EN
    ,
    output logic        period_err
`endif
);

    // EXP_MAX+1 must not wrap to zero.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT < 25'd2 || EXP_MAX == '1) begin : g_bad_param
        $error("slowclk_monitor: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED, STALLED} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [24:0]            cnt_q, cnt_d;
    logic [24:0]            half_q, half_d;
    logic                   valid_q, valid_d;
    logic                   stall_q, stall_d;
    logic [1:0]             sw_q, sw_d;
`ifdef SLOWCLK_PERIOD_CHECK_EN
    logic                   err_q, err_d;
    logic [24:0]            exp_half;
`endif

    logic s_last;
    logic edge_det;
    logic timeout;
    logic mode_chg;

    always_comb begin
        s_last   = sync_q[SYNC_STAGES-1];
        edge_det = s_last ^ prev_q;
        // Edge and timeout in the same cycle: the edge wins.
        timeout  = (cnt_q == TIMEOUT) && !edge_det;
        mode_chg = (switch_clock != sw_q);

        sync_d  = {sync_q[SYNC_STAGES-2:0], slowclk_in};
        prev_d  = s_last;
        rise_d  = s_last & ~prev_q;
        fall_d  = ~s_last & prev_q;
        sw_d    = switch_clock;

        // The edge cycle is cycle 1 of the next interval.
        if (edge_det)
            cnt_d = 25'd1;
        else if (&cnt_q)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 25'd1;

        state_d = state_q;
        half_d  = half_q;
        valid_d = valid_q;
        stall_d = stall_q;
`ifdef SLOWCLK_PERIOD_CHECK_EN
        err_d    = err_q;
        exp_half = (switch_clock == 2'b01) ? EXP_MAX + 25'd1 : 25'd1;
`endif

        case (state_q)
            IDLE: begin
                if (edge_det)
                    state_d = MEASURE;
            end
            MEASURE: begin
                if (edge_det) begin
                    half_d  = cnt_q;
                    valid_d = 1'b1;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (edge_det) begin
                    half_d = cnt_q;
`ifdef SLOWCLK_PERIOD_CHECK_EN
                    if (cnt_q != exp_half)
                        err_d = 1'b1;
`endif
                end
            end
            STALLED: begin
                // The gap that ends the stall is not a valid measurement.
                if (edge_det) begin
                    stall_d = 1'b0;
                    state_d = MEASURE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (timeout && state_q != STALLED) begin
            state_d = STALLED;
            stall_d = 1'b1;
            valid_d = 1'b0;
        end

        // A divider mode change invalidates everything except the ticks and
        // the stale half_period value.
        if (mode_chg) begin
            state_d = IDLE;
            valid_d = 1'b0;
            stall_d = 1'b0;
            cnt_d   = '0;
`ifdef SLOWCLK_PERIOD_CHECK_EN
            err_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge inclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sync_q  <= '0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
            half_q  <= '0;
            valid_q <= 1'b0;
            stall_q <= 1'b0;
            sw_q    <= '0;
`ifdef SLOWCLK_PERIOD_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            valid_q <= valid_d;
            stall_q <= stall_d;
            sw_q    <= sw_d;
`ifdef SLOWCLK_PERIOD_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign rise_tick    = rise_q;
    assign fall_tick    = fall_q;
    assign half_period  = half_q;
    assign period_valid = valid_q;
    assign stall        = stall_q;
`ifdef SLOWCLK_PERIOD_CHECK_EN
    assign period_err   = err_q;
`endif

endmodule
